// File: rtl/multdiv.sv
// multdiv: sequential radix-2 Booth multiplier and restoring divider, result pulse 33 edges after start.
// Define MULTDIV_DIV_EN to build the divider; without it a divide start reports an exception next cycle.
module multdiv (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [64:0] r_p;
    logic [31:0] r_m;
    logic        r_is_div;
    logic [32:0] w_upper;
    logic [32:0] w_m33;
    logic [32:0] w_sum;
    logic [64:0] w_next;
    logic [31:0] w_res;
    logic        w_exc;
    logic        w_mult_exc;

    // Booth add/sub done at 33 bits so a 0x80000000 multiplicand cannot overflow the partial product.
    assign w_upper    = {r_p[64], r_p[64:33]};
    assign w_m33      = {r_m[31], r_m};
    assign w_sum      = (r_p[1:0] == 2'b01) ? w_upper + w_m33 :
                        (r_p[1:0] == 2'b10) ? w_upper - w_m33 : w_upper;
    assign w_mult_exc = ~(&r_p[64:32] | ~|r_p[64:32]);

`ifdef MULTDIV_DIV_EN
    logic        r_neg;
    logic        r_dz;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_quo;
    logic [32:0] w_rs;
    logic [32:0] w_rsub;
    logic        w_ge;

    // Divide reuses r_p as {0, remainder[31:0], quotient/dividend[31:0]}.
    assign w_abs_a = data_operandA[31] ? -data_operandA : data_operandA;
    assign w_abs_b = data_operandB[31] ? -data_operandB : data_operandB;
    assign w_rs    = r_p[63:31];
    assign w_rsub  = w_rs - {1'b0, r_m};
    assign w_ge    = ~w_rsub[32];
    assign w_quo   = r_neg ? -r_p[31:0] : r_p[31:0];
    assign w_next  = ~r_is_div ? {w_sum, r_p[32:1]} :
                     {1'b0, w_ge ? w_rsub[31:0] : w_rs[31:0], r_p[30:0], w_ge};
    assign w_res   = ~r_is_div ? r_p[32:1] : r_dz ? 32'd0 : w_quo;
    assign w_exc   = ~r_is_div ? w_mult_exc : r_dz | (~r_neg & r_p[31]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_neg <= 1'b0;
            r_dz  <= 1'b0;
        end else if (ctrl_DIV && !ctrl_MULT) begin
            r_neg <= data_operandA[31] ^ data_operandB[31];
            r_dz  <= (data_operandB == 32'd0);
        end
    end
`else
    assign w_next = {w_sum, r_p[32:1]};
    assign w_res  = r_is_div ? 32'd0 : r_p[32:1];
    assign w_exc  = r_is_div | w_mult_exc;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= 5'd0;
            r_p            <= '0;
            r_m            <= '0;
            r_is_div       <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            r_cnt          <= 5'd0;
            if (ctrl_MULT) begin
                r_state  <= S_MULT;
                r_p      <= {32'd0, data_operandB, 1'b0};
                r_m      <= data_operandA;
                r_is_div <= 1'b0;
            end else if (ctrl_DIV) begin
                r_is_div <= 1'b1;
`ifdef MULTDIV_DIV_EN
                r_state  <= S_DIV;
                r_p      <= {33'd0, w_abs_a};
                r_m      <= w_abs_b;
`else
                r_state  <= S_DONE;
`endif
            end else if (r_state == S_MULT || r_state == S_DIV) begin
                r_p   <= w_next;
                r_cnt <= r_cnt + 5'd1;
                if (r_cnt == 5'd31)
                    r_state <= S_DONE;
            end else if (r_state == S_DONE) begin
                data_result    <= w_res;
                data_exception <= w_exc;
                data_resultRDY <= 1'b1;
                r_state        <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: directed self-checking bench for multdiv; covers both MULTDIV_DIV_EN builds.
module tb_multdiv;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mult = 1'b0;
    logic        div = 1'b0;
    logic [31:0] res;
    logic        exc;
    logic        rdy;
    int          n_checks = 0;
    int          n_fail = 0;

    multdiv dut (
        .clock(clk),
        .reset(rst),
        .data_operandA(a),
        .data_operandB(b),
        .ctrl_MULT(mult),
        .ctrl_DIV(div),
        .data_result(res),
        .data_exception(exc),
        .data_resultRDY(rdy)
    );

    always #5 clk = ~clk;

    // Start pulse at edge E, then garble the operands so late changes would show up.
    task automatic kick(input logic m, input logic d, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        mult = m;
        div = d;
        a = x;
        b = y;
        @(posedge clk);
        @(negedge clk);
        mult = 1'b0;
        div = 1'b0;
        a = ~x ^ 32'h5A5A5A5A;
        b = y + 32'd17;
    endtask

    task automatic wait_rdy(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        n_checks++; if (res !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=%h", res, 32'd0); end
        n_checks++; if (exc !== 1'b0) begin n_fail++; $display("FAIL reset_exception got=%b exp=0", exc); end
        n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mult;
        logic [31:0] va [9];
        logic [31:0] vb [9];
        logic [31:0] vr [9];
        logic        ve [9];
        int lat;
        va = '{32'd7, 32'h00010000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'd12345, 32'd0};
        vb = '{32'hFFFFFFFD, 32'h00010000, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'hFFFFE57B, 32'h12345678};
        vr = '{32'hFFFFFFEB, 32'd0, 32'h80000000, 32'd1, 32'd0, 32'hFFFFFFFE, 32'h80000000, 32'hFB012863, 32'd0};
        ve = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            kick(1'b1, 1'b0, va[i], vb[i]);
            wait_rdy(lat);
            n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mult[%0d]_latency got=%0d exp=33", i, lat); end
            n_checks++; if (res !== vr[i]) begin n_fail++; $display("FAIL mult[%0d]_result got=%h exp=%h", i, res, vr[i]); end
            n_checks++; if (exc !== ve[i]) begin n_fail++; $display("FAIL mult[%0d]_exception got=%b exp=%b", i, exc, ve[i]); end
            @(negedge clk);
            n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL mult[%0d]_rdy_width got=%b exp=0", i, rdy); end
        end
    endtask

    task automatic test_hold;
        int lat;
        kick(1'b1, 1'b0, 32'h1234, 32'h10);
        wait_rdy(lat);
        repeat (5) @(negedge clk);
        n_checks++; if (res !== 32'h12340) begin n_fail++; $display("FAIL hold_idle_result got=%h exp=%h", res, 32'h12340); end
        kick(1'b1, 1'b0, 32'd3, 32'd3);
        repeat (10) @(negedge clk);
        n_checks++; if (res !== 32'h12340) begin n_fail++; $display("FAIL hold_busy_result got=%h exp=%h", res, 32'h12340); end
        n_checks++; if (exc !== 1'b0) begin n_fail++; $display("FAIL hold_busy_exception got=%b exp=0", exc); end
        wait_rdy(lat);
        n_checks++; if (lat !== 23) begin n_fail++; $display("FAIL hold_next_latency got=%0d exp=23", lat); end
        n_checks++; if (res !== 32'd9) begin n_fail++; $display("FAIL hold_next_result got=%h exp=%h", res, 32'd9); end
    endtask

    task automatic test_priority;
        int lat;
        kick(1'b1, 1'b1, 32'd6, 32'd7);
        wait_rdy(lat);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL priority_latency got=%0d exp=33", lat); end
        n_checks++; if (res !== 32'd42) begin n_fail++; $display("FAIL priority_result got=%h exp=%h", res, 32'd42); end
        n_checks++; if (exc !== 1'b0) begin n_fail++; $display("FAIL priority_exception got=%b exp=0", exc); end
    endtask

    task automatic test_back_to_back;
        int lat;
        int pulses;
        kick(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        kick(1'b1, 1'b0, 32'd5, 32'd6);
        wait_rdy(lat);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL abort_latency got=%0d exp=33", lat); end
        n_checks++; if (res !== 32'd30) begin n_fail++; $display("FAIL abort_result got=%h exp=%h", res, 32'd30); end
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_extra_rdy got=%0d exp=0", pulses); end
    endtask

    task automatic test_reset_mid;
        int lat;
        int pulses;
        kick(1'b1, 1'b0, 32'h7FFFFFFF, 32'd2);
        wait_rdy(lat);
`ifdef MULTDIV_DIV_EN
        kick(1'b0, 1'b1, 32'd1000, 32'd7);
`else
        kick(1'b1, 1'b0, 32'd1000, 32'd7);
`endif
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++; if (res !== 32'd0) begin n_fail++; $display("FAIL midreset_result got=%h exp=%h", res, 32'd0); end
        n_checks++; if (exc !== 1'b0) begin n_fail++; $display("FAIL midreset_exception got=%b exp=0", exc); end
        n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL midreset_rdy got=%b exp=0", rdy); end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (rdy === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midreset_stale_rdy got=%0d exp=0", pulses); end
`ifdef MULTDIV_DIV_EN
        kick(1'b0, 1'b1, 32'd100, 32'd10);
        wait_rdy(lat);
        n_checks++; if (res !== 32'd10) begin n_fail++; $display("FAIL postreset_div_result got=%h exp=%h", res, 32'd10); end
`else
        kick(1'b1, 1'b0, 32'd100, 32'd10);
        wait_rdy(lat);
        n_checks++; if (res !== 32'd1000) begin n_fail++; $display("FAIL postreset_mult_result got=%h exp=%h", res, 32'd1000); end
`endif
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL postreset_latency got=%0d exp=33", lat); end
    endtask

`ifdef MULTDIV_DIV_EN
    task automatic test_div;
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic [31:0] vr [7];
        logic        ve [7];
        int lat;
        va = '{32'hFFFFFFF9, 32'd5, 32'h80000000, 32'd100, 32'hFFFFFF9C, 32'h7FFFFFFF, 32'h80000000};
        vb = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF6, 32'hFFFFFFF9, 32'd1, 32'd2};
        vr = '{32'hFFFFFFFD, 32'd0, 32'h80000000, 32'hFFFFFFF6, 32'd14, 32'h7FFFFFFF, 32'hC0000000};
        ve = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            kick(1'b0, 1'b1, va[i], vb[i]);
            wait_rdy(lat);
            n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div[%0d]_latency got=%0d exp=33", i, lat); end
            n_checks++; if (res !== vr[i]) begin n_fail++; $display("FAIL div[%0d]_result got=%h exp=%h", i, res, vr[i]); end
            n_checks++; if (exc !== ve[i]) begin n_fail++; $display("FAIL div[%0d]_exception got=%b exp=%b", i, exc, ve[i]); end
        end
    endtask
`else
    task automatic test_div_disabled;
        int lat;
        kick(1'b0, 1'b1, 32'd8, 32'd2);
        wait_rdy(lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL nodiv_latency got=%0d exp=1", lat); end
        n_checks++; if (res !== 32'd0) begin n_fail++; $display("FAIL nodiv_result got=%h exp=%h", res, 32'd0); end
        n_checks++; if (exc !== 1'b1) begin n_fail++; $display("FAIL nodiv_exception got=%b exp=1", exc); end
        @(negedge clk);
        n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL nodiv_rdy_width got=%b exp=0", rdy); end
        kick(1'b1, 1'b0, 32'd8, 32'd2);
        wait_rdy(lat);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL nodiv_mult_latency got=%0d exp=33", lat); end
        n_checks++; if (res !== 32'd16) begin n_fail++; $display("FAIL nodiv_mult_result got=%h exp=%h", res, 32'd16); end
        n_checks++; if (exc !== 1'b0) begin n_fail++; $display("FAIL nodiv_mult_exception got=%b exp=0", exc); end
    endtask
`endif

    initial begin
        test_reset();
        test_mult();
        test_hold();
        test_priority();
        test_back_to_back();
        test_reset_mid();
`ifdef MULTDIV_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multdiv.md
MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clock  input  1  rising-edge system clock, shared with the ALU datapath.
REQ-003 reset  input  1  asynchronous, active-high; forces IDLE and clears all outputs.
REQ-004 data_operandA  input  32  signed two's-complement multiplicand/dividend, same source as the ALU operand A.
REQ-005 data_operandB  input  32  signed two's-complement multiplier/divisor, same source as the ALU operand B.
REQ-006 ctrl_MULT  input  1  one-cycle start pulse for multiply.
REQ-007 ctrl_DIV  input  1  one-cycle start pulse for divide.
REQ-008 data_result  output  32  product (low 32 bits) or quotient, held until the next start.
REQ-009 data_exception  output  1  overflow or divide-by-zero flag, valid while data_resultRDY=1 and held afterwards.
REQ-010 data_resultRDY  output  1  single-cycle completion pulse.

Function
REQ-011 States SHALL be IDLE, MULT, DIV and DONE; the reset state is IDLE.
REQ-012 A start pulse sampled high at rising edge E SHALL latch both operands at E, clear the iteration counter, and enter MULT or DIV.
REQ-013 Multiply SHALL use radix-2 Booth iteration, one step per cycle, 32 steps, on a 65-bit product register.
REQ-014 Divide SHALL use restoring division on operand magnitudes, one quotient bit per cycle, 32 steps, with the quotient sign applied as the XOR of the operand signs (truncation toward zero; remainder discarded).
REQ-015 After step 32 the block SHALL enter DONE, and data_resultRDY SHALL be 1 for exactly the cycle following rising edge E+33; it SHALL then return to IDLE.
REQ-016 Multiply exception SHALL be 1 when the 64-bit signed product is not representable in 32 bits (upper 33 bits not all equal); data_result is then the low 32 bits.
REQ-017 Divide-by-zero (operand B = 0) SHALL give data_result=0 and data_exception=1 at the same latency as a normal divide.
REQ-018 0x80000000 / 0xFFFFFFFF SHALL give data_result=0x80000000 and data_exception=1.
REQ-019 A start pulse received while in MULT/DIV/DONE SHALL abort the current operation (no data_resultRDY for it) and restart from REQ-012 with the new operands.
REQ-020 If ctrl_MULT and ctrl_DIV are high at the same edge, multiply SHALL take priority.
REQ-021 Operand changes after the latch edge SHALL NOT affect the result.
REQ-022 data_result and data_exception SHALL update only in the cycle data_resultRDY rises and SHALL hold otherwise.

Reset
REQ-023 Asserting reset SHALL immediately set data_result=0, data_exception=0, data_resultRDY=0, counter=0 and state IDLE, including in the middle of an operation.
REQ-024 The first start pulse sampled after reset deassertion SHALL behave per REQ-012.

Configuration
REQ-025 Macro MULTDIV_DIV_EN defined: divide is implemented per REQ-014/017/018.
REQ-026 MULTDIV_DIV_EN undefined: divide datapath is absent; a ctrl_DIV start SHALL give DONE on the next edge, with data_resultRDY=1 one cycle after the start edge, data_result=0 and data_exception=1; multiply is unchanged.

Verification
REQ-027 MULT 7 x -3 -> data_resultRDY after 33 edges, data_result=0xFFFFFFEB, exception=0.
REQ-028 MULT 0x00010000 x 0x00010000 -> data_result=0x00000000, exception=1; MULT 0x80000000 x 1 -> 0x80000000, exception=0.
REQ-029 DIV -7 / 2 -> data_result=0xFFFFFFFD, exception=0; DIV 5 / 0 -> data_result=0, exception=1 (with MULTDIV_DIV_EN).
REQ-030 Start MULT 3 x 4, then MULT 5 x 6 at edge 10 -> exactly one data_resultRDY, 33 edges after the second start, data_result=30.
REQ-031 Assert reset at edge 15 of a divide -> all outputs 0 at once, no data_resultRDY; the next DIV 100 / 10 -> data_result=10.
REQ-032 Without MULTDIV_DIV_EN: DIV 8 / 2 -> data_resultRDY on the next cycle, data_result=0, exception=1; MULT 8 x 2 -> 16 after 33 edges.
